// File: rtl/pr_node_engine.sv
// pr_node_engine: one PageRank compute node holding N local pages of an
// N*NODES-page graph. Each barrier round it rebuilds every local page value
// from its in-edges (local edges read directly, remote edges fetched over the
// request/response port), then commits the new values after the global sync.
// Committed values are double-buffered so peer queries always see the
// previous iteration.
module pr_node_engine #(
    parameter int              N        = 16,
    parameter int              NODES    = 4,
    parameter int              WIDTH    = 16,
    parameter logic [WIDTH-1:0] D       = 16'h2666,
    parameter int              MAX_ITER = 8,
    localparam int             M        = N * NODES,
    localparam int             PW       = $clog2(M),
    localparam int             IW       = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [N*M-1:0]       adjacency,
    input  logic [N*WIDTH-1:0]   weights,
    input  logic [IW-1:0]        node_id,
    output logic                 req_valid,
    output logic [PW-1:0]        req_page,
    input  logic                 req_ready,
    input  logic                 rsp_valid,
    input  logic [WIDTH-1:0]     rsp_data,
    input  logic                 qry_valid,
    input  logic [PW-1:0]        qry_page,
    output logic                 reply_valid,
    output logic [WIDTH-1:0]     reply_data,
    output logic                 sync_out,
    input  logic                 sync_in,
    output logic [N*WIDTH-1:0]   vals,
    output logic [15:0]          iter_count,
    output logic                 busy,
    output logic                 done
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int AW = (N * M > 1) ? $clog2(N * M) : 1;

    // Fixed-point constants: damped scale (1-d), uniform start value, and
    // the teleport term d/M that seeds every accumulation.
    localparam logic [3*WIDTH-1:0] ONE_W   = (3*WIDTH)'(1) << WIDTH;
    localparam logic [3*WIDTH-1:0] DB      = ONE_W - (3*WIDTH)'(D);
    localparam logic [WIDTH-1:0]   INIT    = WIDTH'(ONE_W / (3*WIDTH)'(M));
    localparam logic [WIDTH-1:0]   DN      = WIDTH'((3*WIDTH)'(D) / (3*WIDTH)'(M));
    localparam logic [WIDTH:0]     ACC_MAX = {1'b0, {WIDTH{1'b1}}};

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_SCAN    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_BARRIER = 3'd5;
    localparam logic [2:0] S_COMMIT  = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    // (1-d) * w * v, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] f_contrib(input logic [WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0] v);
        return WIDTH'((DB * {{(2*WIDTH){1'b0}}, w} * {{(2*WIDTH){1'b0}}, v}) >> (2*WIDTH));
    endfunction

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [2:0]        r_state;
    logic [LW-1:0]     r_p;
    logic [PW-1:0]     r_k;
    logic [WIDTH:0]    r_acc;
    logic [15:0]       r_iter;
    logic [WIDTH-1:0]  r_cur [N];
    logic [WIDTH-1:0]  r_nxt [N];
    logic              r_reply_valid;
    logic [WIDTH-1:0]  r_reply_data;

    logic [WIDTH-1:0]  w_weight [N];
    logic [PW:0]       w_base;
    logic [PW:0]       w_k_off;
    logic              w_k_local;
    logic [LW-1:0]     w_k_idx;
    logic [AW-1:0]     w_adj_idx;
    logic              w_adj_bit;
    logic [PW:0]       w_qry_off;
    logic              w_qry_local;
    logic [LW-1:0]     w_qry_idx;
    logic              w_advance;
    logic [WIDTH-1:0]  w_addend;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_acc_new;

    for (genvar r = 0; r < N; r++) begin : g_lanes
        assign w_weight[r]               = weights[r*WIDTH +: WIDTH];
        assign vals[r*WIDTH +: WIDTH]    = r_cur[r];
    end

    // Local page range of this node and the position of the scanned source.
    assign w_base    = (PW+1)'(node_id) * (PW+1)'(N);
    assign w_k_off   = {1'b0, r_k} - w_base;
    assign w_k_local = ({1'b0, r_k} >= w_base) && (w_k_off < (PW+1)'(N));
    assign w_k_idx   = w_k_off[LW-1:0];
    assign w_adj_idx = AW'(r_p) * AW'(M) + AW'(r_k);
    assign w_adj_bit = adjacency[w_adj_idx];

    assign w_qry_off   = {1'b0, qry_page} - w_base;
    assign w_qry_local = ({1'b0, qry_page} >= w_base) && (w_qry_off < (PW+1)'(N));
    assign w_qry_idx   = w_qry_off[LW-1:0];

    // Hold the internal reset until two clean clock edges after release so
    // deassertion is synchronous while assertion stays immediate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= 2'b00;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Decide whether the current source k is finished this cycle and what it adds.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_advance = 1'b0;
        w_addend  = '0;
        case (r_state)
            S_SCAN: begin
                if (!w_adj_bit) begin
                    w_advance = 1'b1;
                end else if (w_k_local) begin
                    w_advance = 1'b1;
                    w_addend  = f_contrib(w_weight[w_k_idx], r_cur[w_k_idx]);
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    w_advance = 1'b1;
                    w_addend  = rsp_data;
                end
            end
            default: ;
        endcase
    end

    assign w_sum     = r_acc + {1'b0, w_addend};
    assign w_acc_new = (w_sum > ACC_MAX) ? ACC_MAX : w_sum;

    // Iteration FSM: scan every (page, source) pair, fetch remote sources,
    // then wait at the barrier and commit the next-value buffer.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state <= S_IDLE;
            r_p     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_iter  <= '0;
            // NOTE: the value buffers are small register arrays that must hold
            // a defined start value, so they are reset explicitly.
            for (int i = 0; i < N; i++) begin
                r_cur[i] <= INIT;
                r_nxt[i] <= INIT;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_iter  <= '0;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_p     <= '0;
                    r_k     <= '0;
                    r_acc   <= {1'b0, DN};
                    r_state <= S_SCAN;
                end
                S_SCAN, S_WAIT: begin
                    if (w_advance) begin
                        r_state <= S_SCAN;
                        if (r_k == PW'(M - 1)) begin
                            r_nxt[r_p] <= w_acc_new[WIDTH-1:0];
                            if (r_p == LW'(N - 1)) begin
                                r_state <= S_BARRIER;
                            end else begin
                                r_p   <= r_p + LW'(1);
                                r_k   <= '0;
                                r_acc <= {1'b0, DN};
                            end
                        end else begin
                            r_k   <= r_k + PW'(1);
                            r_acc <= w_acc_new;
                        end
                    end else if (r_state == S_SCAN) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_ready) r_state <= S_WAIT;
                end
                S_BARRIER: begin
                    if (sync_in) r_state <= S_COMMIT;
                end
                S_COMMIT: begin
                    r_cur  <= r_nxt;
                    r_iter <= r_iter + 16'd1;
                    r_state <= (r_iter + 16'd1 == 16'(MAX_ITER)) ? S_DONE : S_INIT;
                end
                S_DONE: begin
                    if (start) begin
                        r_iter  <= '0;
                        r_state <= S_INIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Peer query reply, registered one cycle after the strobe from committed values.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_reply_valid <= 1'b0;
            r_reply_data  <= '0;
        end else begin
            r_reply_valid <= qry_valid;
            if (qry_valid && w_qry_local)
                r_reply_data <= f_contrib(w_weight[w_qry_idx], r_cur[w_qry_idx]);
            else
                r_reply_data <= '0;
        end
    end

    assign reply_valid = r_reply_valid;
    assign reply_data  = r_reply_data;
    assign req_valid   = (r_state == S_REQ);
    assign req_page    = req_valid ? r_k : '0;
    assign sync_out    = (r_state == S_BARRIER);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign iter_count  = r_iter;

endmodule

// File: tb/tb_pr_node_engine.sv
// Directed bench for pr_node_engine on a 4-page node of an 8-page graph.
// Single-iteration local-edge cases come from a vector table; remote fetch,
// barrier, query, saturation, MAX_ITER and mid-run reset use short sequences.
module tb_pr_node_engine;

    localparam int N = 4, NODES = 2, WIDTH = 16, M = 8, PW = 3, IW = 1;
    localparam logic [63:0] INIT_VALS = 64'h2000_2000_2000_2000;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [N*M-1:0]    adjacency = '0;
    logic [N*WIDTH-1:0] weights = '0;
    logic [IW-1:0]     node_id = '0;
    logic              req_valid;
    logic [PW-1:0]     req_page;
    logic              req_ready = 1'b0;
    logic              rsp_valid = 1'b0;
    logic [WIDTH-1:0]  rsp_data = '0;
    logic              qry_valid = 1'b0;
    logic [PW-1:0]     qry_page = '0;
    logic              reply_valid;
    logic [WIDTH-1:0]  reply_data;
    logic              sync_out;
    logic              sync_in = 1'b1;
    logic [N*WIDTH-1:0] vals;
    logic [15:0]       iter_count;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;
    int sync_cycles = 0;

    always #5 clk = ~clk;

    pr_node_engine #(
        .N(N), .NODES(NODES), .WIDTH(WIDTH), .D(16'h2666), .MAX_ITER(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .adjacency(adjacency), .weights(weights), .node_id(node_id),
        .req_valid(req_valid), .req_page(req_page), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .qry_valid(qry_valid), .qry_page(qry_page),
        .reply_valid(reply_valid), .reply_data(reply_data),
        .sync_out(sync_out), .sync_in(sync_in),
        .vals(vals), .iter_count(iter_count), .busy(busy), .done(done)
    );

    typedef struct {
        string        name;
        logic [31:0]  adj;
        logic [63:0]  wts;
        logic         node;
        logic [63:0]  exp_vals;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] v0, input logic [15:0] v1,
                                          input logic [15:0] v2, input logic [15:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n   = 1'b0;
        start     = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        qry_valid = 1'b0;
        qry_page  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_iter(input logic [15:0] target, input string name);
        int cyc = 0;
        while (iter_count !== target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (sync_out === 1'b1) sync_cycles++;
        end
        check(name, iter_count, target);
    endtask

    task automatic wait_req(input string name);
        int cyc = 0;
        while (req_valid !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check(name, req_valid, 1);
    endtask

    task automatic wait_sync(input string name);
        int cyc = 0;
        while (sync_out !== 1'b1 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check(name, sync_out, 1);
    endtask

    task automatic serve(input logic [15:0] data, input logic [2:0] page);
        wait_req("serve_req_seen");
        check("serve_req_page", req_page, page);
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = data;
        @(negedge clk);
        rsp_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{"no_edges",    32'h0000_0000, 64'h0,                 1'b0,
                    pack4(16'h04CC, 16'h04CC, 16'h04CC, 16'h04CC)};
        vecs[1] = '{"edge_1_to_0", 32'h0000_0002, 64'h0000_0000_8000_0000, 1'b0,
                    pack4(16'h1265, 16'h04CC, 16'h04CC, 16'h04CC)};
        vecs[2] = '{"node1_multi", 32'h0030_0010, 64'h0000_0000_4000_FFFF, 1'b1,
                    pack4(16'h1FFF, 16'h04CC, 16'h26CB, 16'h04CC)};
        vecs[3] = '{"fan_in_four", 32'h0F00_0400, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                    pack4(16'h04CC, 16'h1FFF, 16'h04CC, 16'h7198)};

        // Reset state.
        do_reset();
        check("rst_vals",        vals, INIT_VALS);
        check("rst_sync_out",    sync_out, 0);
        check("rst_done",        done, 0);
        check("rst_busy",        busy, 0);
        check("rst_req_valid",   req_valid, 0);
        check("rst_req_page",    req_page, 0);
        check("rst_reply_valid", reply_valid, 0);
        check("rst_reply_data",  reply_data, 0);
        check("rst_iter_count",  iter_count, 0);

        // Table: one iteration with only local edges.
        for (int i = 0; i < 4; i++) begin
            do_reset();
            adjacency   = vecs[i].adj;
            weights     = vecs[i].wts;
            node_id     = vecs[i].node;
            sync_in     = 1'b1;
            sync_cycles = 0;
            pulse_start();
            wait_iter(16'd1, $sformatf("%s_iter", vecs[i].name));
            check($sformatf("%s_vals", vecs[i].name), vals, vecs[i].exp_vals);
            check($sformatf("%s_sync_pulses", vecs[i].name), 64'(sync_cycles), 1);
        end

        // Query isolation during iteration 2, MAX_ITER, restart from DONE.
        do_reset();
        adjacency = 32'h0000_0002;
        weights   = 64'h0000_0000_8000_0000;
        node_id   = 1'b0;
        sync_in   = 1'b1;
        pulse_start();
        wait_iter(16'd1, "qry_iter1");
        qry_valid = 1'b1;
        qry_page  = 3'd1;
        @(negedge clk);
        check("qry_p1_reply", {reply_valid, reply_data}, {1'b1, 16'h0209});
        check("qry_busy_iter2", {busy, iter_count}, {1'b1, 16'd1});
        qry_page = 3'd6;
        @(negedge clk);
        check("qry_remote_reply", {reply_valid, reply_data}, {1'b1, 16'h0000});
        qry_valid = 1'b0;
        @(negedge clk);
        check("qry_idle_reply_valid", reply_valid, 0);
        check("qry_vals_iter1", vals, pack4(16'h1265, 16'h04CC, 16'h04CC, 16'h04CC));
        wait_iter(16'd2, "maxiter_iter2");
        check("maxiter_done_busy", {done, busy}, 2'b10);
        check("maxiter_vals", vals, pack4(16'h06D5, 16'h04CC, 16'h04CC, 16'h04CC));
        pulse_start();
        check("restart_state", {done, busy, iter_count}, {1'b0, 1'b1, 16'd0});

        // Barrier hold and commit timing, query during COMMIT.
        do_reset();
        adjacency = 32'h0000_0002;
        weights   = 64'h0000_0000_8000_0000;
        node_id   = 1'b0;
        sync_in   = 1'b0;
        pulse_start();
        wait_sync("barrier_reach");
        for (int i = 0; i < 10; i++) begin
            start = (i == 2);
            @(negedge clk);
            check("barrier_hold_state", {sync_out, iter_count}, {1'b1, 16'd0});
            check("barrier_hold_vals", vals, INIT_VALS);
        end
        start   = 1'b0;
        sync_in = 1'b1;
        @(negedge clk);
        check("commit_cycle_state", {sync_out, iter_count}, {1'b0, 16'd0});
        qry_valid = 1'b1;
        qry_page  = 3'd1;
        @(negedge clk);
        qry_valid = 1'b0;
        check("commit_iter_count", iter_count, 1);
        check("commit_vals", vals, pack4(16'h1265, 16'h04CC, 16'h04CC, 16'h04CC));
        check("commit_qry_precommit", {reply_valid, reply_data}, {1'b1, 16'h0D99});

        // Remote edge 5->0 with backpressure, early stray response, reset with request pending.
        do_reset();
        adjacency = 32'h0000_0020;
        weights   = '0;
        node_id   = 1'b0;
        sync_in   = 1'b1;
        pulse_start();
        wait_req("remote_req_seen");
        check("remote_req_page", req_page, 5);
        for (int i = 0; i < 3; i++) begin
            rsp_valid = (i == 1);
            rsp_data  = 16'h7777;
            @(negedge clk);
            check("remote_req_held", {req_valid, req_page}, {1'b1, 3'd5});
        end
        rsp_valid = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("remote_req_dropped", req_valid, 0);
        @(negedge clk);
        rsp_valid = 1'b1;
        rsp_data  = 16'h0100;
        @(negedge clk);
        rsp_valid = 1'b0;
        wait_iter(16'd1, "remote_iter1");
        check("remote_vals", vals, pack4(16'h05CC, 16'h04CC, 16'h04CC, 16'h04CC));
        wait_req("remote_req_iter2");
        reset_n = 1'b0;
        #1;
        check("remote_rst_req", {req_valid, req_page}, {1'b0, 3'd0});
        check("remote_rst_state", {busy, iter_count}, {1'b0, 16'd0});
        check("remote_rst_vals", vals, INIT_VALS);
        do_reset();

        // Saturation from four full-scale remote responses, then reset mid-SCAN.
        adjacency = 32'h0000_00F0;
        weights   = '0;
        node_id   = 1'b0;
        sync_in   = 1'b1;
        pulse_start();
        for (int i = 0; i < 4; i++) serve(16'hFFFF, 3'(4 + i));
        wait_iter(16'd1, "sat_iter1");
        check("sat_vals", vals, pack4(16'hFFFF, 16'h04CC, 16'h04CC, 16'h04CC));
        repeat (2) @(negedge clk);
        check("sat_scan_busy", {busy, req_valid, sync_out}, 3'b100);
        reset_n = 1'b0;
        #1;
        check("midscan_rst_flags", {busy, done, sync_out, req_valid, reply_valid}, 5'b00000);
        check("midscan_rst_iter", iter_count, 0);
        check("midscan_rst_vals", vals, INIT_VALS);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
